// File: rtl/simd_op_sequencer_pkg.sv
// Shared opcode, state and width definitions for the per-lane SIMD op sequencer.
package simd_op_sequencer_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_INSTR_W = 3 + 3 * DEF_ADDR_W + DEF_DATA_W;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_ADD    = 3'd1;
  localparam logic [2:0] OP_SUB    = 3'd2;
  localparam logic [2:0] OP_BITREV = 3'd3;
  localparam logic [2:0] OP_MUL    = 3'd4;
  localparam logic [2:0] OP_LDI    = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_BITREV) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/simd_op_sequencer_if.sv
// Decoded-instruction handshake from the dispatcher into one lane sequencer.
interface simd_op_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        instr_op;
  logic [ADDR_W-1:0] instr_rd;
  logic [ADDR_W-1:0] instr_rs1;
  logic [ADDR_W-1:0] instr_rs2;
  logic [DATA_W-1:0] instr_imm;

  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
    output instr_ready
  );
endinterface

// File: rtl/simd_op_sequencer_sync_fifo.sv
// Pointer-plus-count synchronous FIFO; head word visible on rdata while non-empty.
module simd_op_sequencer_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy is governed entirely by cnt_q.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/simd_op_sequencer.sv
// Per-lane instruction sequencer: FIFO-buffered decode, then READ/EXEC/WB with one op in flight.
module simd_op_sequencer
  import simd_op_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  simd_op_sequencer_if.slave   instr,
  output logic [ADDR_W-1:0]    rs1,
  output logic [ADDR_W-1:0]    rs2,
  output logic [ADDR_W-1:0]    rd,
  output logic                 rs1_rd_en,
  output logic                 rs2_rd_en,
  output logic                 rd_wr_en,
  output logic [DATA_W-1:0]    wr_data,
  output logic                 Radd_en,
  output logic                 Rsub_en,
  output logic                 bitrev_en,
  output logic                 mul_en,
  input  logic [DATA_W-1:0]    alu_result,
  output logic                 res_valid,
  output logic [DATA_W-1:0]    res_data,
  output logic [ADDR_W-1:0]    res_rd,
  output logic                 illegal_op,
  output logic [15:0]          retired_cnt
);
  localparam int IW = 3 + 3 * ADDR_W + DATA_W;

  logic [IW-1:0]     push_word, head;
  logic              full, empty, pop;
  logic [2:0]        head_op;
  logic [ADDR_W-1:0] head_rd, head_rs1, head_rs2;
  logic [DATA_W-1:0] head_imm;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] cur_rd_q, cur_rd_d;
  logic [ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              illegal_q, illegal_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              busy;

  assign push_word = {instr.instr_op, instr.instr_rd, instr.instr_rs1,
                      instr.instr_rs2, instr.instr_imm};
  assign head_op   = head[IW-1 -: 3];
  assign head_rd   = head[IW-4 -: ADDR_W];
  assign head_rs1  = head[IW-4-ADDR_W -: ADDR_W];
  assign head_rs2  = head[DATA_W+ADDR_W-1 -: ADDR_W];
  assign head_imm  = head[DATA_W-1:0];

  assign instr.instr_ready = ~full;

  simd_op_sequencer_sync_fifo #(
    .WIDTH (IW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (instr.instr_valid & ~full),
    .wdata (push_word),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    op_d      = op_q;
    cur_rd_d  = cur_rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    res_d     = res_q;
    illegal_d = 1'b0;
    cnt_d     = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          op_d     = head_op;
          cur_rd_d = head_rd;
          if (is_alu_op(head_op)) begin
            rs1_d   = head_rs1;
            rs2_d   = head_rs2;
            state_d = ST_READ;
          end else if (head_op == OP_LDI) begin
            res_d   = head_imm;
            rd_d    = head_rd;
            state_d = ST_WB;
          end else if (head_op == OP_NOP) begin
            cnt_d = cnt_q + 16'd1;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: begin
        res_d   = alu_result;
        rd_d    = cur_rd_q;
        state_d = ST_WB;
      end
      ST_WB: begin
        cnt_d   = cnt_q + 16'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NOP;
      cur_rd_q  <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      res_q     <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cur_rd_q  <= cur_rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      res_q     <= res_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  // Operands and enables are held across READ and EXEC for registered RF reads.
  assign busy      = (state_q == ST_READ) || (state_q == ST_EXEC);
  assign rs1_rd_en = busy;
  assign rs2_rd_en = busy;
  assign Radd_en   = busy && (op_q == OP_ADD);
  assign Rsub_en   = busy && (op_q == OP_SUB);
  assign bitrev_en = busy && (op_q == OP_BITREV);
  assign mul_en    = busy && (op_q == OP_MUL);

  assign rd_wr_en    = (state_q == ST_WB);
  assign res_valid   = (state_q == ST_WB);
  assign rs1         = rs1_q;
  assign rs2         = rs2_q;
  assign rd          = rd_q;
  assign res_rd      = rd_q;
  assign wr_data     = res_q;
  assign res_data    = res_q;
  assign illegal_op  = illegal_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_simd_op_sequencer.sv
// Randomized + directed bench for simd_op_sequencer against an in-order scoreboard model.
module tb_simd_op_sequencer;
  import simd_op_sequencer_pkg::*;

  localparam int DW = 16;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  simd_op_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  logic [AW-1:0] rs1, rs2, rd, res_rd;
  logic          rs1_rd_en, rs2_rd_en, rd_wr_en, res_valid, illegal_op;
  logic          Radd_en, Rsub_en, bitrev_en, mul_en;
  logic [DW-1:0] wr_data, res_data, alu_result;
  logic [15:0]   retired_cnt;

  simd_op_sequencer #(.FIFO_DEPTH(4), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .instr(bus),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .rs1_rd_en(rs1_rd_en), .rs2_rd_en(rs2_rd_en), .rd_wr_en(rd_wr_en),
    .wr_data(wr_data),
    .Radd_en(Radd_en), .Rsub_en(Rsub_en), .bitrev_en(bitrev_en), .mul_en(mul_en),
    .alu_result(alu_result),
    .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd),
    .illegal_op(illegal_op), .retired_cnt(retired_cnt)
  );

  function automatic logic [DW-1:0] bitrev(input logic [DW-1:0] a);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = a[DW-1-i];
    return r;
  endfunction

  function automatic logic [DW-1:0] alu_ref(input logic [2:0] op, input logic [DW-1:0] a, b);
    case (op)
      OP_ADD:    return a + b;
      OP_SUB:    return a - b;
      OP_BITREV: return bitrev(a);
      OP_MUL:    return a * b;
      default:   return '0;
    endcase
  endfunction

  function automatic logic [3:0] exp_en(input logic [2:0] op);
    case (op)
      OP_ADD:    return 4'b1000;
      OP_SUB:    return 4'b0100;
      OP_BITREV: return 4'b0010;
      OP_MUL:    return 4'b0001;
      default:   return 4'b0000;
    endcase
  endfunction

  // Lane environment: register file written by the DUT and a combinational ALU.
  logic [DW-1:0] rf [32] = '{default: '0};
  always @(posedge clk) if (rd_wr_en) rf[rd] <= wr_data;

  always_comb begin
    alu_result = '0;
    if (Radd_en)        alu_result = alu_ref(OP_ADD,    rf[rs1], rf[rs2]);
    else if (Rsub_en)   alu_result = alu_ref(OP_SUB,    rf[rs1], rf[rs2]);
    else if (bitrev_en) alu_result = alu_ref(OP_BITREV, rf[rs1], rf[rs2]);
    else if (mul_en)    alu_result = alu_ref(OP_MUL,    rf[rs1], rf[rs2]);
  end

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] rd, rs1, rs2;
    logic [DW-1:0] imm;
  } ins_t;

  ins_t          q[$];
  logic [DW-1:0] mrf [32] = '{default: '0};
  int            nchk = 0, nerr = 0;
  int            n_alu = 0, n_ill = 0, exp_ret = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: in-order retirement of accepted instructions against the model register file.
  ins_t          mh;
  logic [DW-1:0] expd;
  logic [3:0]    en_m;
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      n_alu = 0;
    end else begin
      while (q.size() > 0 && q[0].op == OP_NOP) void'(q.pop_front());
      en_m = {Radd_en, Rsub_en, bitrev_en, mul_en};
      if (en_m != 4'b0) begin
        n_alu++;
        chk("alu_queue", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          chk("alu_en", 32'(en_m), 32'(exp_en(q[0].op)));
          chk("rd_en", {rs1_rd_en, rs2_rd_en}, 2'b11);
          chk("rs1", rs1, q[0].rs1);
          chk("rs2", rs2, q[0].rs2);
        end
      end
      if (illegal_op) begin
        n_ill++;
        chk("ill_queue", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          mh = q.pop_front();
          chk("ill_op", 32'(mh.op >= 3'd6), 1);
          chk("ill_alu", n_alu, 0);
        end
        n_alu = 0;
      end
      if (res_valid || rd_wr_en) begin
        chk("wb_queue", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          mh   = q.pop_front();
          expd = (mh.op == OP_LDI) ? mh.imm : alu_ref(mh.op, mrf[mh.rs1], mrf[mh.rs2]);
          chk("wb_both", {res_valid, rd_wr_en}, 2'b11);
          chk("res_data", res_data, expd);
          chk("wr_data", wr_data, expd);
          chk("res_rd", res_rd, mh.rd);
          chk("rd", rd, mh.rd);
          chk("alu_cycles", n_alu, (mh.op == OP_LDI) ? 0 : 2);
          mrf[mh.rd] = expd;
        end
        n_alu = 0;
      end
    end
  end

  task automatic push(input logic [2:0] op, input logic [AW-1:0] d, s1, s2,
                      input logic [DW-1:0] imm, output int stalls);
    ins_t t;
    t.op = op; t.rd = d; t.rs1 = s1; t.rs2 = s2; t.imm = imm;
    stalls = 0;
    bus.instr_valid = 1'b1;
    bus.instr_op = op; bus.instr_rd = d; bus.instr_rs1 = s1;
    bus.instr_rs2 = s2; bus.instr_imm = imm;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (bus.instr_ready) begin
        q.push_back(t);
        if (op < 3'd6) exp_ret++;
        @(posedge clk); #1;
        return;
      end
      stalls++;
      @(posedge clk); #1;
    end
    chk("push_timeout", stalls, 0);
  endtask

  task automatic wait_res(output int n);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (res_valid) begin n = k; break; end
    end
  endtask

  task automatic settle(input int cyc);
    bus.instr_valid = 1'b0;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, st, first, ill0, live;
    bus.instr_valid = 1'b0;
    bus.instr_op = '0; bus.instr_rd = '0; bus.instr_rs1 = '0;
    bus.instr_rs2 = '0; bus.instr_imm = '0;

    // Reset held for three cycles
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", bus.instr_ready, 1);
    chk("rst_cnt", retired_cnt, 0);
    chk("rst_en", {rs1_rd_en, rs2_rd_en, rd_wr_en, Radd_en, Rsub_en, bitrev_en, mul_en}, 0);
    chk("rst_out", {res_valid, illegal_op, res_data, wr_data, rd, res_rd}, 0);
    @(posedge clk); #1;

    // Single ADD after two LDIs
    push(OP_LDI, 5'd1, 5'd0, 5'd0, 16'h0003, st); bus.instr_valid = 1'b0;
    wait_res(n); chk("ldi_lat", n, 2);
    @(posedge clk); #1;
    push(OP_LDI, 5'd2, 5'd0, 5'd0, 16'h0005, st); bus.instr_valid = 1'b0;
    wait_res(n); chk("ldi2_lat", n, 2);
    @(posedge clk); #1;
    push(OP_ADD, 5'd3, 5'd1, 5'd2, 16'h0, st); bus.instr_valid = 1'b0;
    wait_res(n); chk("add_lat", n, 4);
    chk("add_data", res_data, 16'h0008);
    chk("add_rd", rd, 5'd3);
    settle(3);
    chk("add_ret", retired_cnt, 3);

    // Back-to-back fill: ready must drop on the sixth offer
    first = -1;
    for (int i = 0; i < 6; i++) begin
      logic [2:0] ops [6];
      ops = '{OP_SUB, OP_BITREV, OP_MUL, OP_ADD, OP_SUB, OP_NOP};
      push(ops[i], 5'($urandom_range(1, 31)), 5'($urandom), 5'($urandom), 16'($urandom), st);
      if (st > 0 && first < 0) first = i;
    end
    settle(30);
    chk("fill_stall_at", first, 5);
    chk("fill_ret", retired_cnt, 16'(exp_ret));

    // Illegal opcode between two ADDs
    ill0 = n_ill;
    push(OP_ADD, 5'd4, 5'd1, 5'd2, 16'h0, st);
    push(3'd7,   5'd5, 5'd1, 5'd2, 16'h0, st);
    push(OP_ADD, 5'd6, 5'd3, 5'd4, 16'h0, st);
    settle(20);
    chk("ill_pulses", n_ill - ill0, 1);
    chk("ill_ret", retired_cnt, 16'(exp_ret));

    // Reset during EXEC of a MUL
    push(OP_MUL, 5'd7, 5'd3, 5'd4, 16'h0, st); bus.instr_valid = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("mid_exec", mul_en, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_abort", {res_valid, rd_wr_en, mul_en}, 3'b000);
    rst = 1'b1;
    exp_ret = 0;
    @(negedge clk);
    chk("mid_idle", {res_valid, rd_wr_en, mul_en, rs1_rd_en}, 4'b0000);
    chk("mid_ready", bus.instr_ready, 1);
    chk("mid_cnt", retired_cnt, 0);
    @(posedge clk); #1;
    settle(6);

    // LDI latency into idle block
    push(OP_LDI, 5'd31, 5'd0, 5'd0, 16'hBEEF, st); bus.instr_valid = 1'b0;
    wait_res(n);
    chk("ldi31_lat", n, 2);
    chk("ldi31_wb", {rd_wr_en, rd, wr_data}, {1'b1, 5'd31, 16'hBEEF});
    chk("ldi31_noalu", {Radd_en, Rsub_en, bitrev_en, mul_en}, 4'b0);
    @(posedge clk); #1;

    // Randomized traffic with idle gaps
    for (int i = 0; i < 200; i++) begin
      push(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), st);
      if ($urandom_range(0, 2) == 0) begin
        bus.instr_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    settle(40);
    live = 0;
    foreach (q[i]) if (q[i].op != OP_NOP) live++;
    chk("rand_drained", live, 0);
    chk("rand_ret", retired_cnt, 16'(exp_ret));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
